hazard_stall_unit: RTL and testbench

- Producer-side companion to the EX-stage operand forwarding logic of the 5-stage MIPS pipeline.
- Forwarding resolves hazards by selecting newer data into EX. This block handles the hazards forwarding cannot resolve: load-use, multi-cycle MUL/DIV occupancy and taken-branch squash.
- Drives write-enables and flushes for PC, IF/ID, ID/EX and EX/MEM.
- Holds the MUL/DIV busy FSM and its countdown.

---
 rtl/hazard_stall_unit.sv | 135 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard stall/flush control: load-use, MUL/DIV occupancy and taken-branch squash.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_stall_unit #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        if_id_rs,
    input  logic [4:0]        if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              id_ex_memread,
    input  logic [4:0]        id_ex_rt,
    input  logic              ex_mdu_start,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_write,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes
);

    typedef enum logic [0:0] {StRun, StMduWait} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mdu_done_q;
    logic               load_use;
    logic               mdu_enter;

    // $0 is hardwired zero, so a load "to" it never produces a real dependency
    assign load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    // A squashed instruction must not start the MDU
    assign mdu_enter = ex_mdu_start && !ex_branch_taken;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_busy     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ex_mdu_start) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            StMduWait: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                mdu_busy     = 1'b1;
                // On the last cycle EX/MEM captures the finished result
                ex_mem_flush = (cnt_q != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            mdu_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    mdu_done_q <= 1'b0;
                    if (mdu_enter) begin
                        state_q <= StMduWait;
                        cnt_q   <= CNT_W'(MDU_LATENCY - 2);
                    end
                end
                StMduWait: begin
                    if (cnt_q != '0) begin
                        cnt_q      <= cnt_q - 1'b1;
                        mdu_done_q <= 1'b0;
                    end else begin
                        state_q    <= StRun;
                        mdu_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    cnt_q      <= '0;
                    mdu_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign mdu_done = mdu_done_q;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!pc_write)  perf_stall_q <= perf_stall_q + 1'b1;
            if (if_id_flush) perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (MDU_LATENCY=4).
module tb_hazard_stall_unit;

    localparam int unsigned PERF_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        if_id_rs, if_id_rt, id_ex_rt;
    logic              if_id_uses_rt, id_ex_memread, ex_mdu_start, ex_branch_taken;
    logic              pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic              ex_mem_flush, mdu_busy, mdu_done;
    logic [PERF_W-1:0] perf_stall_cycles, perf_flushes;

    int total = 0;
    int bad   = 0;

    hazard_stall_unit #(.MDU_LATENCY(4), .CNT_W(4), .PERF_W(PERF_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .if_id_uses_rt    (if_id_uses_rt),
        .id_ex_memread    (id_ex_memread),
        .id_ex_rt         (id_ex_rt),
        .ex_mdu_start     (ex_mdu_start),
        .ex_branch_taken  (ex_branch_taken),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_write      (id_ex_write),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .mdu_busy         (mdu_busy),
        .mdu_done         (mdu_done),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flushes     (perf_flushes)
    );

    always #5 clk = ~clk;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, mdu_busy, mdu_done}
    localparam logic [7:0] Idle  = 8'b1101_0000;
    localparam logic [7:0] Lduse = 8'b0001_1000;
    localparam logic [7:0] Squash = 8'b1111_1000;
    localparam logic [7:0] MduGo = 8'b0000_0100;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       mdu;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [7:0] outs();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_flush, mdu_busy, mdu_done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b0;
        id_ex_memread = 1'b0; id_ex_rt = 5'd0;
        ex_mdu_start = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic drive_load_use();
        if_id_rs = 5'd8; id_ex_rt = 5'd8; id_ex_memread = 1'b1;
    endtask

    // Expected per-cycle outputs of a MUL starting at cycle 0
    logic [7:0] mul_exp[6];

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, Idle};
        vecs[1]  = '{5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, Lduse};
        vecs[2]  = '{5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, Lduse};
        vecs[3]  = '{5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, Idle};
        vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, Idle};
        vecs[5]  = '{5'd8, 5'd3, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, Idle};
        vecs[6]  = '{5'd7, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, Idle};
        vecs[7]  = '{5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, Squash};
        vecs[8]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, MduGo};
        vecs[9]  = '{5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, MduGo};
        vecs[10] = '{5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, Squash};
        vecs[11] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, Squash};

        mul_exp[0] = 8'b0000_0100;
        mul_exp[1] = 8'b0000_0110;
        mul_exp[2] = 8'b0000_0110;
        mul_exp[3] = 8'b0000_0010;
        mul_exp[4] = 8'b1101_0001;
        mul_exp[5] = Idle;

        drive_idle();
        rst_n = 1'b0;
        #12;
        check("reset_outputs", 32'(outs()), 32'(Idle));
        check("reset_perf_stall", perf_stall_cycles, 32'd0);
        check("reset_perf_flush", perf_flushes, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational decode in RUN; inputs go idle again before the next rising edge
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if_id_rs = vecs[i].rs; if_id_rt = vecs[i].rt; if_id_uses_rt = vecs[i].uses_rt;
            id_ex_memread = vecs[i].memread; id_ex_rt = vecs[i].ex_rt;
            ex_mdu_start = vecs[i].mdu; ex_branch_taken = vecs[i].br;
            #1;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            drive_idle();
        end

        // Load-use across a clock: one stall cycle, then the load has advanced
        @(negedge clk);
        drive_load_use();
        #1 check("lu_stall", 32'(outs()), 32'(Lduse));
        @(negedge clk);
        drive_idle();
        #1 check("lu_release", 32'(outs()), 32'(Idle));

        // MUL: start cycle plus three wait cycles; load-use held during wait must be ignored
        @(negedge clk);
        ex_mdu_start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 check($sformatf("mul_cycle%0d", c), 32'(outs()), 32'(mul_exp[c]));
            @(negedge clk);
            drive_idle();
            if (c < 2) begin
                drive_load_use();
                ex_branch_taken = 1'b1;
            end
        end
        drive_idle();

        // Squashed MDU start must not enter the wait state
        @(negedge clk);
        ex_mdu_start = 1'b1; ex_branch_taken = 1'b1;
        @(negedge clk);
        drive_idle();
        #1 check("squashed_mdu_no_wait", 32'(outs()), 32'(Idle));

        // Reset while cnt==1 in the wait state
        @(negedge clk);
        ex_mdu_start = 1'b1;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        #1 check("pre_reset_busy", 32'(mdu_busy), 32'd1);
        rst_n = 1'b0;
        #1 check("mid_reset_outputs", 32'(outs()), 32'(Idle));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check($sformatf("post_reset%0d", c), 32'(outs()), 32'(Idle));
        end

        // Counter workload from a fresh reset: 1 load-use + 4-cycle MUL + 1 taken branch
        @(negedge clk);
        drive_load_use();
        @(negedge clk);
        drive_idle();
        ex_mdu_start = 1'b1;
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
`ifdef HAZARD_PERF_EN
        check("perf_stall_cycles", perf_stall_cycles, 32'd5);
        check("perf_flushes", perf_flushes, 32'd1);
`else
        check("perf_stall_tied", perf_stall_cycles, 32'd0);
        check("perf_flush_tied", perf_flushes, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
